branch_feedback_tracker: RTL and testbench

Feedback-side partner of the branch predictor. It records every prediction issued at fetch in an in-order queue. When execute resolves the oldest in-flight branch, it produces the predictor's feedback transaction: valid, pc, prediction and outcome. On a misprediction it also raises a redirect with the correct PC and discards all younger in-flight predictions. It sits between the fetch stage (allocate), the execute stage (resolve) and the predictor's feedback interface.

---
 rtl/branch_feedback_tracker.sv | 181 ++++++++++++++++++
 tb/tb_branch_feedback_tracker.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_feedback_tracker.sv
// In-order tracker of issued branch predictions. It returns feedback to the predictor and raises mispredict redirects.
// Build option BRANCH_FB_STATS_EN adds counters for resolved branches and mispredicts.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package mips_core_pkg;
  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } BranchOutcome;
endpackage

module branch_feedback_tracker
  import mips_core_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_alloc_valid,
  input  logic [`ADDR_WIDTH-1:0] i_alloc_pc,
  input  logic [`ADDR_WIDTH-1:0] i_alloc_target,
  input  BranchOutcome           i_alloc_prediction,
  output logic                   o_alloc_ready,
  input  logic                   i_res_valid,
  input  BranchOutcome           i_res_outcome,
  input  logic                   i_flush,
  output logic                   o_fb_valid,
  output logic [`ADDR_WIDTH-1:0] o_fb_pc,
  output BranchOutcome           o_fb_prediction,
  output BranchOutcome           o_fb_outcome,
  output logic                   o_redirect_valid,
  output logic [`ADDR_WIDTH-1:0] o_redirect_pc,
  output logic [PTR_W:0]         o_count,
`ifdef BRANCH_FB_STATS_EN
  output logic [31:0]            o_stat_resolved,
  output logic [31:0]            o_stat_mispredict,
`endif
  output logic                   o_underflow
);

  typedef logic [`ADDR_WIDTH-1:0] addr_t;

  typedef struct packed {
    addr_t        pc;
    addr_t        target;
    BranchOutcome prediction;
  } entry_t;

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  entry_t           mem_q [DEPTH];
  entry_t           head_entry;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  logic             fb_valid_q, fb_valid_d;
  addr_t            fb_pc_q, fb_pc_d;
  BranchOutcome     fb_prediction_q, fb_prediction_d;
  BranchOutcome     fb_outcome_q, fb_outcome_d;
  logic             redirect_valid_q, redirect_valid_d;
  addr_t            redirect_pc_q, redirect_pc_d;
  logic             underflow_q, underflow_d;

  logic             res_fire;
  logic             mispredict;
  logic             alloc_fire;

  // No bypass: readiness depends only on the registered occupancy.
  assign o_alloc_ready = (count_q != FULL_COUNT);

  always_comb begin
    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    head_entry = mem_q[head_q];
    res_fire   = i_res_valid && (count_q != '0);
    mispredict = res_fire && (head_entry.prediction != i_res_outcome);
    alloc_fire = i_alloc_valid && o_alloc_ready && !mispredict && !i_flush;

    head_d = head_q + PTR_W'(res_fire);

    if (mispredict || i_flush) begin
      // The younger entries are discarded: the queue restarts empty at the new head.
      tail_d  = head_d;
      count_d = '0;
    end else begin
      tail_d  = tail_q + PTR_W'(alloc_fire);
      count_d = count_q + (PTR_W+1)'(alloc_fire) - (PTR_W+1)'(res_fire);
    end

    fb_valid_d      = res_fire;
    fb_pc_d         = fb_pc_q;
    fb_prediction_d = fb_prediction_q;
    fb_outcome_d    = fb_outcome_q;
    if (res_fire) begin
      fb_pc_d         = head_entry.pc;
      fb_prediction_d = head_entry.prediction;
      fb_outcome_d    = i_res_outcome;
    end

    redirect_valid_d = mispredict;
    redirect_pc_d    = redirect_pc_q;
    if (mispredict) begin
      redirect_pc_d = (i_res_outcome == TAKEN) ? head_entry.target
                                               : head_entry.pc + addr_t'(4);
    end

    underflow_d = underflow_q || (i_res_valid && (count_q == '0));
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      fb_valid_q       <= 1'b0;
      fb_pc_q          <= '0;
      fb_prediction_q  <= NOT_TAKEN;
      fb_outcome_q     <= NOT_TAKEN;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      underflow_q      <= 1'b0;
    end else begin
      head_q           <= head_d;
      tail_q           <= tail_d;
      count_q          <= count_d;
      fb_valid_q       <= fb_valid_d;
      fb_pc_q          <= fb_pc_d;
      fb_prediction_q  <= fb_prediction_d;
      fb_outcome_q     <= fb_outcome_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      underflow_q      <= underflow_d;
    end
  end

  // NOTE: entry storage is not reset; the pointers and count keep stale entries unobservable.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      mem_q[tail_q] <= '{pc: i_alloc_pc, target: i_alloc_target, prediction: i_alloc_prediction};
    end
  end

`ifdef BRANCH_FB_STATS_EN
  logic [31:0] stat_resolved_q, stat_resolved_d;
  logic [31:0] stat_mispredict_q, stat_mispredict_d;

  always_comb begin
    stat_resolved_d   = stat_resolved_q + 32'(res_fire);
    stat_mispredict_d = stat_mispredict_q + 32'(mispredict);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_resolved_q   <= '0;
      stat_mispredict_q <= '0;
    end else begin
      stat_resolved_q   <= stat_resolved_d;
      stat_mispredict_q <= stat_mispredict_d;
    end
  end

  assign o_stat_resolved   = stat_resolved_q;
  assign o_stat_mispredict = stat_mispredict_q;
`endif

  assign o_fb_valid       = fb_valid_q;
  assign o_fb_pc          = fb_pc_q;
  assign o_fb_prediction  = fb_prediction_q;
  assign o_fb_outcome     = fb_outcome_q;
  assign o_redirect_valid = redirect_valid_q;
  assign o_redirect_pc    = redirect_pc_q;
  assign o_count          = count_q;
  assign o_underflow      = underflow_q;

endmodule

// File: tb/tb_branch_feedback_tracker.sv
// Self-checking bench for branch_feedback_tracker: directed scenarios followed by randomized traffic.
// The expected values come from a queue-based reference model.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module tb_branch_feedback_tracker;
  import mips_core_pkg::*;

  localparam int DEPTH = 8;
  localparam int PTR_W = $clog2(DEPTH);

  typedef logic [`ADDR_WIDTH-1:0] addr_t;

  typedef struct {
    addr_t pc;
    addr_t tgt;
    bit    pred;
  } ent_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           i_alloc_valid = 1'b0;
  addr_t          i_alloc_pc = '0;
  addr_t          i_alloc_target = '0;
  BranchOutcome   i_alloc_prediction = NOT_TAKEN;
  logic           o_alloc_ready;
  logic           i_res_valid = 1'b0;
  BranchOutcome   i_res_outcome = NOT_TAKEN;
  logic           i_flush = 1'b0;
  logic           o_fb_valid;
  addr_t          o_fb_pc;
  BranchOutcome   o_fb_prediction;
  BranchOutcome   o_fb_outcome;
  logic           o_redirect_valid;
  addr_t          o_redirect_pc;
  logic [PTR_W:0] o_count;
  logic           o_underflow;
`ifdef BRANCH_FB_STATS_EN
  logic [31:0]    o_stat_resolved;
  logic [31:0]    o_stat_mispredict;
`endif

  branch_feedback_tracker #(.DEPTH(DEPTH)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_alloc_valid      (i_alloc_valid),
    .i_alloc_pc         (i_alloc_pc),
    .i_alloc_target     (i_alloc_target),
    .i_alloc_prediction (i_alloc_prediction),
    .o_alloc_ready      (o_alloc_ready),
    .i_res_valid        (i_res_valid),
    .i_res_outcome      (i_res_outcome),
    .i_flush            (i_flush),
    .o_fb_valid         (o_fb_valid),
    .o_fb_pc            (o_fb_pc),
    .o_fb_prediction    (o_fb_prediction),
    .o_fb_outcome       (o_fb_outcome),
    .o_redirect_valid   (o_redirect_valid),
    .o_redirect_pc      (o_redirect_pc),
    .o_count            (o_count),
`ifdef BRANCH_FB_STATS_EN
    .o_stat_resolved    (o_stat_resolved),
    .o_stat_mispredict  (o_stat_mispredict),
`endif
    .o_underflow        (o_underflow)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  ent_t        mq[$];
  bit          e_fb_valid, e_rd_valid;
  addr_t       m_fb_pc, m_rd_pc;
  bit          m_fb_pred, m_fb_out, m_underflow;
  int unsigned m_stat_res, m_stat_mis;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("fb_valid", o_fb_valid, e_fb_valid);
    check("fb_pc", o_fb_pc, m_fb_pc);
    check("fb_prediction", o_fb_prediction, m_fb_pred);
    check("fb_outcome", o_fb_outcome, m_fb_out);
    check("redirect_valid", o_redirect_valid, e_rd_valid);
    check("redirect_pc", o_redirect_pc, m_rd_pc);
    check("count", o_count, mq.size());
    check("underflow", o_underflow, m_underflow);
`ifdef BRANCH_FB_STATS_EN
    check("stat_resolved", o_stat_resolved, m_stat_res);
    check("stat_mispredict", o_stat_mispredict, m_stat_mis);
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_alloc_valid = 1'b0;
    i_res_valid = 1'b0;
    i_flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mq.delete();
    e_fb_valid = 0; e_rd_valid = 0;
    m_fb_pc = '0; m_rd_pc = '0; m_fb_pred = 0; m_fb_out = 0;
    m_underflow = 0; m_stat_res = 0; m_stat_mis = 0;
    check_outputs();
    check("reset_ready", o_alloc_ready, 1'b1);
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive inputs, advance the model, clock, then compare.
  task automatic step(input bit av, input addr_t apc, input addr_t atgt, input bit apred,
                      input bit rv, input bit rout, input bit fl);
    bit   ready_exp, mis;
    ent_t e;
    i_alloc_valid      = av;
    i_alloc_pc         = apc;
    i_alloc_target     = atgt;
    i_alloc_prediction = BranchOutcome'(apred);
    i_res_valid        = rv;
    i_res_outcome      = BranchOutcome'(rout);
    i_flush            = fl;

    ready_exp = (mq.size() < DEPTH);
    check("alloc_ready", o_alloc_ready, ready_exp);

    e_fb_valid = 0;
    e_rd_valid = 0;
    mis = 0;
    if (rv && mq.size() > 0) begin
      e = mq.pop_front();
      e_fb_valid = 1;
      m_fb_pc = e.pc;
      m_fb_pred = e.pred;
      m_fb_out = rout;
      m_stat_res++;
      if (e.pred != rout) begin
        mis = 1;
        e_rd_valid = 1;
        m_rd_pc = rout ? e.tgt : e.pc + 4;
        m_stat_mis++;
      end
    end else if (rv) begin
      m_underflow = 1;
    end
    if (mis || fl) mq.delete();
    else if (av && ready_exp) mq.push_back('{pc: apc, tgt: atgt, pred: apred});

    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle();
    step(0, '0, '0, 0, 0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit    av, rv, fl, rout;
    addr_t pc;

    do_reset();

    // Correct TAKEN prediction
    step(1, 32'h100, 32'h200, 1, 0, 0, 0);
    step(0, '0, '0, 0, 1, 1, 0);
    idle();

    // Mispredicts in both directions, including PC wrap on the fall-through
    step(1, 32'h100, 32'h180, 0, 0, 0, 0);
    step(0, '0, '0, 0, 1, 1, 0);
    step(1, 32'h100, 32'h180, 1, 0, 0, 0);
    step(0, '0, '0, 0, 1, 0, 0);
    step(1, 32'hFFFF_FFFC, 32'h40, 1, 0, 0, 0);
    step(0, '0, '0, 0, 1, 0, 0);

    // Fill, refused alloc when full, drain, pointer wrap
    for (int i = 0; i < DEPTH; i++) step(1, 32'h1000 + 32'(i * 4), 32'h2000, i[0], 0, 0, 0);
    step(1, 32'h3000, 32'h3100, 1, 1, 0, 0);
    for (int i = 1; i < DEPTH; i++) step(0, '0, '0, 0, 1, i[0], 0);
    step(1, 32'h4000, 32'h4400, 1, 0, 0, 0);
    for (int i = 0; i < 12; i++) step(1, 32'h5000 + 32'(i * 8), 32'h6000, 1, 1, 1, 0);
    step(0, '0, '0, 0, 1, 1, 0);

    // Mispredict with concurrent alloc, then resolve on empty queue
    for (int i = 0; i < 3; i++) step(1, 32'h7000 + 32'(i * 4), 32'h7800, 0, 0, 0, 0);
    step(1, 32'h7100, 32'h7900, 1, 1, 1, 0);
    step(0, '0, '0, 0, 1, 1, 0);
    idle();

    // Flush with a concurrent correct resolve
    do_reset();
    step(1, 32'h8000, 32'h8800, 1, 0, 0, 0);
    step(1, 32'h8004, 32'h8900, 0, 0, 0, 0);
    step(1, 32'h8008, 32'h8a00, 0, 1, 1, 1);
    idle();
    // Flush with a mispredict: single redirect, empty queue
    step(1, 32'h8100, 32'h8200, 1, 0, 0, 0);
    step(1, 32'h8104, 32'h8300, 1, 0, 0, 0);
    step(0, '0, '0, 0, 1, 0, 1);
    idle();

    // Five resolves with two mispredicts, then a reset pulse
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1, 32'h9000 + 32'(i * 4), 32'h9800, 1, 0, 0, 0);
      step(0, '0, '0, 0, 1, (i == 1 || i == 3) ? 1'b0 : 1'b1, 0);
    end
    do_reset();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      av = ($urandom_range(0, 9) < 6);
      rv = ($urandom_range(0, 9) < 4);
      fl = ($urandom_range(0, 19) == 0);
      if (mq.size() > 0 && $urandom_range(0, 4) != 0) rout = mq[0].pred;
      else rout = 1'($urandom);
      pc = $urandom;
      pc[1:0] = 2'b00;
      step(av, pc, $urandom, 1'($urandom), rv, rout, fl);
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
